// File: rtl/fib_bcd.sv
// fib_bcd: serial binary-to-BCD converter (double-dabble, one bit per clock)
// Display stage that turns a binary Fibonacci result into packed decimal digits.
module fib_bcd #(
    parameter int w = 32,
    parameter int d = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [w-1:0]   bin,
    output logic           busy,
    output logic           done,
    output logic [4*d-1:0] bcd
);

    localparam int CW = $clog2(w + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(w);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [w-1:0]     sh;
    logic [4*d-1:0]   acc;
    logic [CW-1:0]    cnt;

    logic [4*d-1:0]   corr;
    logic [4*d-1:0]   nxt;

    // add-3 correction on every digit >= 5, then shift in the next binary bit
    always_comb begin
        corr = acc;
        for (int i = 0; i < d; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        nxt = {corr[4*d-2:0], sh[w-1]};
    end

    // conversion sequencer with registered busy/done/bcd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= bin;
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= nxt;
                    sh  <= {sh[w-2:0], 1'b0};
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        bcd   <= nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_bcd.sv
// tb_fib_bcd: directed bench for the serial binary-to-BCD converter
// Expected decimal results are hand-written or derived by repeated division.
module tb_fib_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [39:0] bcd;

    int errors;
    int checks;

    fib_bcd #(.w(32), .d(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [39:0] r;
        x = v;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] pat(input int c);
        return 32'(c * 123457 + 89);
    endfunction

    task automatic conv(input logic [31:0] v, input logic [39:0] exp,
                        input string tag);
        int n;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'd32);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " bcd"}, 64'(bcd), 64'(exp));
        @(negedge clk);
        check({tag, " done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int bad;
        int ndone;
        logic [39:0] cap;
        errors = 0;
        checks = 0;
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;

        // asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst bcd", 64'(bcd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done || bcd != '0) bad++;
        end
        check("idle quiet", 64'(bad), 64'd0);

        conv(32'd55, 40'h0000000055, "fib10");
        repeat (5) @(negedge clk);
        check("fib10 hold", 64'(bcd), 64'h0000000055);

        conv(32'd0, 40'h0, "zero");
        conv(32'hFFFF_FFFF, 40'h4294967295, "max");
        conv(32'd3524578, 40'h0003524578, "fib33");

        // start pulses during a conversion, including the final edge
        @(negedge clk);
        start = 1'b1;
        bin   = 32'd89;
        ndone = 0;
        cap   = '0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap = bcd;
            end
            start = (k == 5 || k == 32);
            bin   = 32'd144;
        end
        start = 1'b0;
        check("busy_start done_count", 64'(ndone), 64'd1);
        check("busy_start bcd", 64'(cap), 64'h0000000089);

        // back-to-back with start held high and bin changing each cycle
        for (int c = 0; c <= 99; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check($sformatf("b2b done c%0d", c), 64'(done),
                      64'((c % 33) == 0));
                if ((c % 33) == 0)
                    check($sformatf("b2b bcd c%0d", c), 64'(bcd),
                          64'(to_bcd(pat(c - 33))));
            end
            start = (c != 99);
            bin   = pat(c);
        end
        start = 1'b0;
        @(negedge clk);

        // reset in the middle of a conversion of 233
        @(negedge clk);
        start = 1'b1;
        bin   = 32'd233;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid busy pre", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid busy", 64'(busy), 64'd0);
        check("mid bcd", 64'(bcd), 64'd0);
        check("mid done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid no_done", 64'(ndone), 64'd0);
        conv(32'd377, 40'h0000000377, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
